// File: rtl/shift_arbiter.sv
// Round-robin arbiter for the shared right-shifter between two requesters.
// The SHIFT_ARB_ZERO_BYPASS_EN macro lets amt == 0 skip the shifter (1-cycle latency).
module shift_arbiter #(
  parameter int unsigned DW = 8,
  parameter int unsigned SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  input  logic [SW-1:0] amt0,
  input  logic [SW-1:0] amt1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  input  logic          rready0,
  input  logic          rready1,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] sh_ip,
  output logic [SW-1:0] sh_s,
  input  logic [DW-1:0] sh_out,
  output logic          busy
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e        r_state;
  logic          r_owner;
  logic          r_last;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_op;
  logic [SW-1:0] r_amt;
  logic [DW-1:0] r_rdata;

  logic          w_any;
  logic          w_win;
  logic [DW-1:0] w_win_data;
  logic [SW-1:0] w_win_amt;
  logic          w_owner_ready;
  logic          w_bypass;

  assign w_any = req0 | req1;
  // Under contention the requester that did not win last time gets the grant.
  assign w_win         = (req0 && req1) ? ~r_last : req1;
  assign w_win_data    = w_win ? data1 : data0;
  assign w_win_amt     = w_win ? amt1 : amt0;
  assign w_owner_ready = r_owner ? rready1 : rready0;

`ifdef SHIFT_ARB_ZERO_BYPASS_EN
  assign w_bypass = (w_win_amt == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // r_op/r_amt hold the operand only while in EXEC, so they double as the shifter drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_op      <= '0;
      r_amt     <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_owner <= w_win;
            r_last  <= w_win;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            if (w_bypass) begin
              r_rdata   <= w_win_data;
              r_rvalid0 <= ~w_win;
              r_rvalid1 <= w_win;
              r_state   <= StResp;
            end else begin
              r_op    <= w_win_data;
              r_amt   <= w_win_amt;
              r_state <= StExec;
            end
          end
        end
        StExec: begin
          r_gnt0    <= 1'b0;
          r_gnt1    <= 1'b0;
          r_op      <= '0;
          r_amt     <= '0;
          r_rdata   <= sh_out;
          r_rvalid0 <= ~r_owner;
          r_rvalid1 <= r_owner;
          r_state   <= StResp;
        end
        StResp: begin
          r_gnt0 <= 1'b0;
          r_gnt1 <= 1'b0;
          if (w_owner_ready) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = r_rdata;
  assign sh_ip   = r_op;
  assign sh_s    = r_amt;
  assign busy    = (r_state != StIdle);

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Owns the single shared 8-bit right-shifter datapath instance.
- Shares it between two requesters: port 0 is the ALU execute stage, port 1 is the address/immediate formatting path.
- Round-robin arbitration, operand latching, shifter sequencing and a registered result with valid/ready handshake per requester.
- Sits beside the ALU; the shifter's ip/s inputs are driven only from this block, and its out is sampled only here.

Parameters:
- DW, 8, operand/result width; must match the shifter width.
- SW, 3, shift-amount width (log2 DW).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  shift request from requester 0 / 1; held until gnt seen.
- data0 / data1  in  DW  operand for requester 0 / 1.
- amt0 / amt1  in  SW  shift amount for requester 0 / 1.
- gnt0 / gnt1  out  1  one-cycle grant pulse; operand has been latched.
- rvalid0 / rvalid1  out  1  result valid for requester 0 / 1.
- rready0 / rready1  in  1  requester accepts result.
- rdata  out  DW  result (shared; qualified by rvalid0/1).
- sh_ip  out  DW  to shifter ip.
- sh_s  out  SW  to shifter s.
- sh_out  in  DW  from shifter out (combinational, same cycle).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n is low, all state goes to IDLE. All outputs go to 0: gnt, rvalid, rdata, sh_ip, sh_s, busy. Internal last_grant resets to 1, so requester 0 wins the first contention.
- Reset mid-operation: the in-flight result is discarded and no rvalid is issued. The requester re-requests.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req0 or req1 is high at the clock edge, arbitrate and go to EXEC.
  - Arbitration: if only one request is high, grant it. If both are high, grant the requester not equal to last_grant.
  - On that edge: latch the winner's data/amt into op_r/amt_r, set owner_r = winner, set last_grant = winner.
- EXEC (exactly 1 cycle):
  - gnt[owner_r] = 1 for this cycle only.
  - sh_ip = op_r, sh_s = amt_r; sh_ip/sh_s are 0 in all other states.
  - At the edge, rdata <= sh_out, then go to RESP.
- RESP:
  - rvalid[owner_r] = 1 and rdata is held stable.
  - On an edge with rready[owner_r] = 1: rvalid drops, go to IDLE.
  - rready of the non-owner is ignored.
  - Stays in RESP indefinitely without rready. New requests wait; there is no queuing.
- Latency, req to rvalid: 2 cycles (IDLE edge, EXEC edge). Sustained throughput is one result per 3 cycles when rready is held high.
- Requester rules:
  - Hold data/amt stable while req is high.
  - Drop req on the cycle gnt is seen. If req is still high when the block returns to IDLE, it is treated as a new request.
- amt = 0: passes through EXEC normally (shifter returns the operand).
- rdata retains its last value after rvalid drops.
- Invariants: gnt0 and gnt1 are never both high; rvalid0 and rvalid1 are never both high; busy == (state != IDLE).

Optional Feature:
- Macro: SHIFT_ARB_ZERO_BYPASS_EN.
- Defined: a granted request with amt == 0 skips EXEC.
  - On the IDLE edge, rdata <= data directly and the FSM goes straight to RESP.
  - gnt pulses in the first RESP cycle, together with rvalid.
  - Latency is 1 cycle, and sh_ip/sh_s stay 0.
- Not defined: amt == 0 takes the normal EXEC path with 2-cycle latency.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC with req0 pending -> all outputs 0 immediately, state IDLE. After release, req0 is re-served.
- Single request: req0, data0=0xB4, amt0=2, rready0=1 -> gnt0 pulse in cycle 1, rvalid0 in cycle 2, rdata equals the shifter output for (0xB4, 2), sh_s=2 only in EXEC.
- Contention: req0 and req1 high from reset, each dropped on its own gnt -> grant order 0, 1. Both requests re-asserted together -> grant order 0, 1 again, driven by last_grant alternation.
- Backpressure: rready1=0 for 5 cycles with req0 arriving meanwhile -> rvalid1 and rdata stable, gnt0 not issued. Once rready1=1, req0 is granted on the following IDLE edge.
- Wrong-owner ready: owner is 1, rready0=1, rready1=0 -> the block stays in RESP.
- Zero bypass with SHIFT_ARB_ZERO_BYPASS_EN defined: req0, data0=0x5A, amt0=0 -> rvalid0 and gnt0 one cycle after the request, rdata=0x5A, sh_ip never nonzero. With the macro undefined -> 2-cycle latency.
